dedicated_counter_processor: RTL and testbench
==============================================

// Module: dedicated_counter_processor
// PURPOSE
//   Parametrised successor of the team's 0-to-9 dedicated counter processor.
//   Control FSM plus datapath counts up or down between 0 and a run-time limit,
//   with selectable wrap or halt, start/stop control, a done pulse and a busy flag.
//   All logic runs on clk. The prescaler produces a 1-cycle tick enable; no
//   derived clock exists. Drives display/LED logic at the top level.
// PARAMETERS
//   WIDTH     8           counter, limit and out width (bits)
//   PRESCALE  10_000_000  clk cycles per count step; >=1 (1 = step every cycle)
// PORTS
//   clk       in   1      system clock, rising edge
//   reset     in   1      asynchronous, active-low reset
//   start     in   1      level, sampled each clk; (re)start a count run
//   stop      in   1      level; abort run, go idle (priority over start)
//   dir       in   1      0 = count up 0->limit, 1 = count down limit->0
//   wrap_en   in   1      1 = wrap at terminal value and continue, 0 = halt
//   limit     in   WIDTH  terminal value (up) / start value (down)
//   out       out  WIDTH  registered count value
//   busy      out  1      1 while in LOAD or RUN
//   done      out  1      1-cycle pulse when out takes the terminal value
//   wrap_cnt  out  16     completed wraps (only with DCP_WRAP_CNT_EN)
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE; A, out, prescaler count = 0; busy=0, done=0, wrap_cnt=0.
//   - Prescaler: count 0..PRESCALE-1; tick=1 for one clk when count==PRESCALE-1, then count=0.
//     Count is cleared in LOAD, so the first step comes PRESCALE clks after entering RUN.
//   - FSM states: IDLE, LOAD, RUN, HOLD (encoding from dcp_pkg).
//     IDLE: out holds its value; start -> LOAD.
//     LOAD (1 clk): latch dir, limit and wrap_en into shadow registers.
//       Set A = out = (dir ? limit : 0). If the load value is terminal, pulse done;
//       then -> HOLD if !wrap_en, else -> RUN. Otherwise -> RUN.
//     RUN, on tick: terminal T = (dir ? 0 : limit).
//       If A != T: A = A +/- 1. If the new A == T, pulse done (same cycle out updates);
//       if !wrap_en, -> HOLD.
//       If A == T (wrap_en only): A = (dir ? limit : 0); wrap_cnt++.
//     HOLD: out frozen at T, busy=0; start -> LOAD.
//   - stop=1 in LOAD/RUN/HOLD -> IDLE on the next clk; out keeps its last value.
//     stop and start both high: stop wins.
//   - Inputs dir, limit and wrap_en change only in LOAD. Mid-run changes are ignored.
//   - Equality compare only; no overflow. limit = 2^WIDTH-1 is legal.
//   - limit=0 with wrap_en: A stays 0 and done pulses on every tick.
//   - done and busy are registered; out = A (buffer register, updated with A).
// CONFIGURATION
//   DCP_WRAP_CNT_EN defined: wrap_cnt port and a 16-bit counter exist. The counter
//     increments on each wrap, saturates at 16'hFFFF and clears in LOAD and on reset.
//   DCP_WRAP_CNT_EN undefined: no port, no counter; all other behaviour unchanged.
// STRUCTURE
//   dcp_pkg: FSM state localparams (IDLE/LOAD/RUN/HOLD) and WRAP_CNT_W = 16.
//   Sub-module dcp_prescaler (PRESCALE param; clk, reset, clr -> tick).
//   FSM and datapath stay in this file.
// TESTING (PRESCALE=2, WIDTH=8 unless noted)
//   1. limit=9, dir=0, wrap_en=0, start pulse -> out 0,1..9, one step per 2 clk;
//      done pulses once with out=9; busy falls; out stays 9.
//   2. limit=3, wrap_en=1 -> out 0,1,2,3,0,1..; done at each 3;
//      wrap_cnt = 2 after two wraps (macro on).
//   3. limit=5, dir=1, wrap_en=0 -> out 5,4,3,2,1,0; done with out=0; HOLD.
//   4. limit=0, wrap_en=0 -> done in LOAD cycle, out=0, busy=0 next clk.
//   5. stop at out=4 -> IDLE, out stays 4. start+stop together -> stays IDLE.
//      start -> out reloads 0.
//   6. reset=0 mid-run at out=6 -> out=0, busy=0, done=0 immediately (async).
//      Release -> IDLE.

Source files
------------

// File: rtl/dcp_pkg.sv
// Shared definitions for the dedicated counter processor: FSM state encoding
// and the wrap counter width used when DCP_WRAP_CNT_EN is defined.
package dcp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } dcp_state_t;

    localparam int WRAP_CNT_W = 16;

endpackage

// File: rtl/dcp_prescaler.sv
// Step-rate prescaler: emits a one-cycle tick every PRESCALE clocks.
// clr restarts the period so the first tick lands PRESCALE clocks after release.
module dcp_prescaler #(
    parameter int PRESCALE = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: tick is decoded from the count register itself, so it is high on the
    // same cycle the count sits at its last value and needs no extra flop.
    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/dedicated_counter_processor.sv
// Up/down counter with run-time limit, wrap/halt mode and start/stop control.
// Define DCP_WRAP_CNT_EN to add the saturating wrap_cnt output.
module dedicated_counter_processor
    import dcp_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 10_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  dir,
    input  logic                  wrap_en,
    input  logic [WIDTH-1:0]      limit,
    output logic [WIDTH-1:0]      out,
    output logic                  busy,
    output logic                  done
`ifdef DCP_WRAP_CNT_EN
    ,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);

    dcp_state_t       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] out_q;
    logic             busy_q;
    logic             done_q;
    logic             dir_q;
    logic             wrap_q;
    logic [WIDTH-1:0] limit_q;

    logic             tick;
    logic [WIDTH-1:0] term_d;
    logic [WIDTH-1:0] reload_d;
    logic [WIDTH-1:0] step_d;
    logic [WIDTH-1:0] load_val_d;

    dcp_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == LOAD),
        .tick  (tick)
    );

    // Run-time decisions use the shadow copies; only LOAD looks at the live inputs.
    assign term_d     = dir_q ? '0 : limit_q;
    assign reload_d   = dir_q ? limit_q : '0;
    assign step_d     = dir_q ? a_q - 1'b1 : a_q + 1'b1;
    assign load_val_d = dir ? limit : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
            limit_q <= '0;
        end else begin
            done_q <= 1'b0;
            // NOTE: stop is tested ahead of the state case so it beats start everywhere.
            if (stop && state_q != IDLE) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, HOLD: begin
                        if (start && !stop) begin
                            state_q <= LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                    LOAD: begin
                        dir_q   <= dir;
                        limit_q <= limit;
                        wrap_q  <= wrap_en;
                        a_q     <= load_val_d;
                        out_q   <= load_val_d;
                        state_q <= RUN;
                        if (limit == '0) begin
                            done_q <= 1'b1;
                            if (!wrap_en) begin
                                state_q <= HOLD;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            if (a_q != term_d) begin
                                a_q   <= step_d;
                                out_q <= step_d;
                                if (step_d == term_d) begin
                                    done_q <= 1'b1;
                                    if (!wrap_q) begin
                                        state_q <= HOLD;
                                        busy_q  <= 1'b0;
                                    end
                                end
                            end else begin
                                a_q    <= reload_d;
                                out_q  <= reload_d;
                                done_q <= (reload_d == term_d);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef DCP_WRAP_CNT_EN
    logic [WRAP_CNT_W-1:0] wrap_cnt_q;
    logic                  wrap_evt;

    assign wrap_evt = (state_q == RUN) && !stop && tick && (a_q == term_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_cnt_q <= '0;
        end else if (state_q == LOAD) begin
            wrap_cnt_q <= '0;
        end else if (wrap_evt && wrap_cnt_q != '1) begin
            wrap_cnt_q <= wrap_cnt_q + 1'b1;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`endif

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_dedicated_counter_processor.sv
// Randomised bench for dedicated_counter_processor against a closed-form run model.
// Checks wrap_cnt too when DCP_WRAP_CNT_EN is defined.
module tb_dedicated_counter_processor;

    localparam int W = 8;
    localparam int P = 2;

    localparam int END_STOP  = 0;
    localparam int END_BOTH  = 1;
    localparam int END_RESET = 2;
    localparam int END_NONE  = 3;

    logic         clk     = 1'b0;
    logic         reset   = 1'b0;
    logic         start   = 1'b0;
    logic         stop    = 1'b0;
    logic         dir     = 1'b0;
    logic         wrap_en = 1'b0;
    logic [W-1:0] limit   = '0;
    logic [W-1:0] out;
    logic         busy;
    logic         done;
`ifdef DCP_WRAP_CNT_EN
    logic [15:0]  wrap_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cur_out = 0;

    always #5 clk = ~clk;

    dedicated_counter_processor #(
        .WIDTH    (W),
        .PRESCALE (P)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .wrap_en  (wrap_en),
        .limit    (limit),
        .out      (out),
        .busy     (busy),
        .done     (done)
`ifdef DCP_WRAP_CNT_EN
        ,
        .wrap_cnt (wrap_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs k clocks after the LOAD edge: s = k/P steps taken, values from arithmetic.
    function automatic void model(input int lim, input bit d, input bit w, input int k,
                                  output int val, output int dn, output int bsy, output int wc);
        int s, r, m, t;
        s = k / P;
        t = d ? 0 : lim;
        if (w) begin
            r   = s % (lim + 1);
            val = d ? lim - r : r;
            bsy = 1;
            wc  = s / (lim + 1);
            if (wc > 65535) wc = 65535;
            dn  = (k % P == 0 && val == t) ? 1 : 0;
        end else begin
            m   = (s < lim) ? s : lim;
            val = d ? lim - m : m;
            bsy = (s < lim) ? 1 : 0;
            wc  = 0;
            dn  = (k % P == 0 && s == lim) ? 1 : 0;
        end
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_out"}, out, cur_out);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic run_case(input int lim, input bit d, input bit w, input int ncyc, input int mode);
        int ev, ed, eb, ewc;
        eb = 1;
        limit   = W'(lim);
        dir     = d;
        wrap_en = w;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_load_busy", busy, 1);
        check("pre_load_out", out, cur_out);
        check("pre_load_done", done, 0);
        for (int k = 0; k <= ncyc; k++) begin
            @(negedge clk);
            model(lim, d, w, k, ev, ed, eb, ewc);
            check("out", out, ev);
            check("done", done, ed);
            check("busy", busy, eb);
`ifdef DCP_WRAP_CNT_EN
            check("wrap_cnt", wrap_cnt, ewc);
`endif
            cur_out = ev;
            limit   = W'($urandom);
            dir     = 1'($urandom_range(0, 1));
            wrap_en = 1'($urandom_range(0, 1));
        end
        if (mode == END_NONE && eb != 0) mode = END_STOP;
        if (mode == END_STOP || mode == END_BOTH) begin
            stop  = 1'b1;
            start = (mode == END_BOTH);
            @(negedge clk);
            check_idle("stop");
            if (mode == END_BOTH) begin
                @(negedge clk);
                check_idle("stop_start");
            end
            stop  = 1'b0;
            start = 1'b0;
        end else if (mode == END_RESET) begin
            #2;
            reset = 1'b0;
            #1;
            cur_out = 0;
            check_idle("async_rst");
`ifdef DCP_WRAP_CNT_EN
            check("async_rst_wc", wrap_cnt, 0);
`endif
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check_idle("post_rst");
        end
    endtask

    initial begin
        int lim, ncyc, mode;
        bit d, w;
        #1;
        check_idle("reset");
`ifdef DCP_WRAP_CNT_EN
        check("reset_wc", wrap_cnt, 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("idle");

        run_case(9,   1'b0, 1'b0, 9 * P + 4,   END_NONE);
        run_case(3,   1'b0, 1'b1, 4 * 2 * P + 3, END_STOP);
        run_case(5,   1'b1, 1'b0, 5 * P + 4,   END_NONE);
        run_case(0,   1'b0, 1'b0, 3,           END_NONE);
        run_case(0,   1'b0, 1'b1, 3 * P + 1,   END_STOP);
        run_case(9,   1'b0, 1'b0, 4 * P,       END_BOTH);
        run_case(9,   1'b0, 1'b0, 6 * P,       END_RESET);
        run_case(255, 1'b0, 1'b0, 255 * P + 3, END_NONE);
        run_case(255, 1'b1, 1'b1, 256 * P + 4, END_STOP);

        for (int i = 0; i < 40; i++) begin
            lim  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 255))
                                               : int'($urandom_range(0, 15));
            d    = 1'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            ncyc = $urandom_range(0, (lim + 1) * P * 2 + 2);
            if (ncyc > 600) ncyc = 600;
            mode = $urandom_range(0, 3);
            run_case(lim, d, w, ncyc, mode);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
